// File: rtl/einstein_int_ctrl_pkg.sv
// Shared constants for the Einstein internal interrupt controller: source indices,
// default vectors and the INTA FSM state type.
package einstein_pkg;
  localparam int NUM_SRC  = 3;
  localparam int SRC_KB   = 0;
  localparam int SRC_ADC  = 1;
  localparam int SRC_FIRE = 2;

  localparam logic [7:0] VEC_KB_DEF   = 8'h0E;
  localparam logic [7:0] VEC_ADC_DEF  = 8'h0A;
  localparam logic [7:0] VEC_FIRE_DEF = 8'h0C;

  typedef enum logic {IDLE, ACK} state_t;
endpackage

// File: rtl/einstein_int_ctrl_if.sv
// Z80-side bus of the interrupt controller: cycle strobes, mask port selects,
// data in, and the INT_n / vector return path.
interface einstein_int_ctrl_if;
  logic       m1_n, iorq_n, rd_n, wr_n, reti;
  logic       kb_msk_n, adc_msk_n, fire_msk_n;
  logic [7:0] din;
  logic       int_n, vec_oe;
  logic [7:0] vec;

  modport slave (input m1_n, iorq_n, rd_n, wr_n, reti, kb_msk_n, adc_msk_n, fire_msk_n, din,
                 output int_n, vec, vec_oe);
  modport master(output m1_n, iorq_n, rd_n, wr_n, reti, kb_msk_n, adc_msk_n, fire_msk_n, din,
                 input int_n, vec, vec_oe);
endinterface

// File: rtl/einstein_int_ctrl_src.sv
// One interrupt source: optional synchroniser, rising-edge detect, mask and pending flops.
module einstein_int_src #(
  parameter int SYNC_STAGES = 2,
  parameter bit BYPASS      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic msk_wr,
  input  logic msk_rd,
  input  logic wr_val,
  input  logic ack_clr,
  output logic mask,
  output logic pending
);
  logic s, prev, rise;

  generate
    if (BYPASS) begin : g_byp
      assign s = src;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      always_ff @(posedge clk or posedge rst)
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], src};
      assign s = sync[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~prev;

  // A mask write of 1 beats a fresh edge; a fresh edge beats read/ack clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 1'b0;
      mask    <= 1'b1;
      pending <= 1'b0;
    end else begin
      prev <= s;
      if (msk_wr) mask <= wr_val;
      if (msk_wr && wr_val)      pending <= 1'b0;
      else if (rise && !mask)    pending <= 1'b1;
      else if (msk_rd || ack_clr) pending <= 1'b0;
    end
  end
endmodule

// File: rtl/einstein_int_ctrl.sv
// IM2 interrupt controller for keyboard / ADC / fire with fixed priority kb > adc > fire.
// ADC source is present only when EINSTEIN_ADC_INT_EN is defined.
module einstein_int_ctrl
  import einstein_pkg::*;
#(
  parameter logic [7:0] VEC_KB      = VEC_KB_DEF,
  parameter logic [7:0] VEC_ADC     = VEC_ADC_DEF,
  parameter logic [7:0] VEC_FIRE    = VEC_FIRE_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  einstein_int_ctrl_if.slave   bus,
  input  logic                 kb_evt,
  input  logic                 fire_in,
  input  logic                 adc_eoc,
  input  logic                 iei,
  output logic                 ieo,
  output logic [NUM_SRC-1:0]   mask
);
  state_t             state, state_nx;
  logic [NUM_SRC-1:0] pending, in_service, eligible, win_oh, ack_clr, reti_clr;
  logic [NUM_SRC-1:0] sel_n, wr_s, rd_s;
  logic               inta, ack, int_q;
  logic [7:0]         vec_q, win_vec;

  assign sel_n = {bus.fire_msk_n, bus.adc_msk_n, bus.kb_msk_n};
  assign wr_s  = ~sel_n & {NUM_SRC{~bus.wr_n}};
  assign rd_s  = ~sel_n & {NUM_SRC{~bus.rd_n}};

  einstein_int_src #(.SYNC_STAGES(SYNC_STAGES), .BYPASS(1'b1)) u_kb (
    .clk(clk_sys), .rst(reset), .src(kb_evt), .msk_wr(wr_s[SRC_KB]), .msk_rd(rd_s[SRC_KB]),
    .wr_val(bus.din[0]), .ack_clr(ack_clr[SRC_KB]), .mask(mask[SRC_KB]), .pending(pending[SRC_KB]));

  einstein_int_src #(.SYNC_STAGES(SYNC_STAGES), .BYPASS(1'b0)) u_fire (
    .clk(clk_sys), .rst(reset), .src(fire_in), .msk_wr(wr_s[SRC_FIRE]), .msk_rd(rd_s[SRC_FIRE]),
    .wr_val(bus.din[0]), .ack_clr(ack_clr[SRC_FIRE]), .mask(mask[SRC_FIRE]), .pending(pending[SRC_FIRE]));

`ifdef EINSTEIN_ADC_INT_EN
  einstein_int_src #(.SYNC_STAGES(SYNC_STAGES), .BYPASS(1'b0)) u_adc (
    .clk(clk_sys), .rst(reset), .src(adc_eoc), .msk_wr(wr_s[SRC_ADC]), .msk_rd(rd_s[SRC_ADC]),
    .wr_val(bus.din[0]), .ack_clr(ack_clr[SRC_ADC]), .mask(mask[SRC_ADC]), .pending(pending[SRC_ADC]));
  logic [6:0] unused_din;
  assign unused_din = bus.din[7:1];
`else
  assign mask[SRC_ADC]    = 1'b1;
  assign pending[SRC_ADC] = 1'b0;
  logic [8:0] unused_adc;
  assign unused_adc = {adc_eoc, wr_s[SRC_ADC], rd_s[SRC_ADC], ack_clr[SRC_ADC], bus.din[7:3]};
`endif

  // Index order equals priority order, so "equal or higher" is every bit at or below s.
  assign eligible[SRC_KB]   = pending[SRC_KB]   & ~in_service[SRC_KB];
  assign eligible[SRC_ADC]  = pending[SRC_ADC]  & ~|in_service[SRC_ADC:SRC_KB];
  assign eligible[SRC_FIRE] = pending[SRC_FIRE] & ~|in_service;

  always_comb begin
    win_oh  = '0;
    win_vec = VEC_FIRE;
    if (eligible[SRC_KB])       begin win_oh[SRC_KB]   = 1'b1; win_vec = VEC_KB;  end
    else if (eligible[SRC_ADC]) begin win_oh[SRC_ADC]  = 1'b1; win_vec = VEC_ADC; end
    else if (eligible[SRC_FIRE])      win_oh[SRC_FIRE] = 1'b1;
  end

  assign inta     = ~bus.m1_n & ~bus.iorq_n;
  assign reti_clr = {NUM_SRC{bus.reti}} & in_service & (~in_service + 3'd1);

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    case (state)
      IDLE: if (inta && !int_q && iei && |eligible) begin
              state_nx = ACK;
              ack      = 1'b1;
            end
      ACK:  if (!inta) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ack_clr = ack ? win_oh : '0;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      int_q      <= 1'b1;
      in_service <= '0;
      vec_q      <= 8'h00;
    end else begin
      state      <= state_nx;
      int_q      <= ~(iei & |eligible);
      in_service <= (in_service & ~reti_clr) | ack_clr;
      if (ack) vec_q <= win_vec;
    end
  end

  assign bus.int_n  = int_q;
  assign bus.vec    = vec_q;
  assign bus.vec_oe = (state == ACK);
  assign ieo        = iei & ~|in_service & ~|pending;
endmodule

// File: tb/tb_einstein_int_ctrl.sv
// Randomized scoreboard bench for einstein_int_ctrl; acks are checked by a monitor
// against vectors queued by a priority/mask/in-service reference model.
module tb_einstein_int_ctrl;
`ifdef EINSTEIN_ADC_INT_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1;
  logic       kb_evt = 1'b0, fire_in = 1'b0, adc_eoc = 1'b0, iei = 1'b1;
  logic       ieo;
  logic [2:0] mask;
  einstein_int_ctrl_if bus();

  einstein_int_ctrl dut (.clk_sys(clk), .reset(reset), .bus(bus), .kb_evt(kb_evt),
    .fire_in(fire_in), .adc_eoc(adc_eoc), .iei(iei), .ieo(ieo), .mask(mask));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [7:0] exp_q[$];
  bit m_mask[3], m_pend[3], m_isv[3];
  logic prev_oe = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] vec_of(input int s);
    return (s == 0) ? 8'h0E : (s == 1) ? 8'h0A : 8'h0C;
  endfunction

  function automatic bit present(input int s);
    return (s != 1) || ADC_EN;
  endfunction

  // A source may interrupt if nothing of its own or higher priority is being serviced.
  function automatic bit elig(input int s);
    bit blocked = 1'b0;
    for (int h = 0; h <= s; h++) if (m_isv[h]) blocked = 1'b1;
    return m_pend[s] && !blocked;
  endfunction

  function automatic bit any_elig();
    return elig(0) || elig(1) || elig(2);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin m_mask[s] = 1'b1; m_pend[s] = 1'b0; m_isv[s] = 1'b0; end
  endtask

  always @(negedge clk) begin
    if (bus.vec_oe && !prev_oe) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 8'h01, 8'h00);
      else chk("ack_vec", bus.vec, exp_q.pop_front());
    end
    prev_oe = bus.vec_oe;
  end

  task automatic idle_bus();
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.reti = 1'b0;
    bus.kb_msk_n = 1'b1; bus.adc_msk_n = 1'b1; bus.fire_msk_n = 1'b1; bus.din = 8'h00;
  endtask

  task automatic sel(input int s, input logic v);
    case (s)
      0: bus.kb_msk_n = v;
      1: bus.adc_msk_n = v;
      default: bus.fire_msk_n = v;
    endcase
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    bit exp_ieo = iei && !(m_isv[0] || m_isv[1] || m_isv[2]) && !(m_pend[0] || m_pend[1] || m_pend[2]);
    chk({tag, "_int_n"}, {7'd0, bus.int_n}, {7'd0, !(iei && any_elig())});
    chk({tag, "_ieo"},   {7'd0, ieo},       {7'd0, exp_ieo});
    chk({tag, "_mask"},  {5'd0, mask},      {5'd0, m_mask[2], m_mask[1], m_mask[0]});
  endtask

  task automatic do_op(input int op, input int s, input bit v);
    @(negedge clk);
    case (op)
      0: begin
        if (s == 0) begin kb_evt = 1'b1; wait_cyc(1); kb_evt = 1'b0; end
        else begin
          if (s == 1) adc_eoc = 1'b1; else fire_in = 1'b1;
          wait_cyc(3); adc_eoc = 1'b0; fire_in = 1'b0;
        end
        if (present(s) && !m_mask[s]) m_pend[s] = 1'b1;
      end
      1: begin
        bus.wr_n = 1'b0; sel(s, 1'b0); bus.din = {$urandom_range(0, 127), v};
        wait_cyc(1); idle_bus();
        if (present(s)) begin m_mask[s] = v; if (v) m_pend[s] = 1'b0; end
      end
      2: begin
        bus.rd_n = 1'b0; sel(s, 1'b0); wait_cyc(1); idle_bus();
        if (present(s)) m_pend[s] = 1'b0;
      end
      3: begin
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        if (iei && any_elig()) begin
          int w = elig(0) ? 0 : elig(1) ? 1 : 2;
          exp_q.push_back(vec_of(w));
          m_pend[w] = 1'b0; m_isv[w] = 1'b1;
        end
        wait_cyc(3); idle_bus();
      end
      4: begin
        bus.reti = 1'b1; wait_cyc(1); idle_bus();
        if (m_isv[0]) m_isv[0] = 1'b0;
        else if (m_isv[1]) m_isv[1] = 1'b0;
        else m_isv[2] = 1'b0;
      end
      5: begin
        kb_evt = 1'b1; bus.rd_n = 1'b0; bus.kb_msk_n = 1'b0;
        wait_cyc(1); kb_evt = 1'b0; idle_bus();
        m_pend[0] = !m_mask[0];
      end
      6: begin
        kb_evt = 1'b1; bus.wr_n = 1'b0; bus.kb_msk_n = 1'b0; bus.din = 8'h01;
        wait_cyc(1); kb_evt = 1'b0; idle_bus();
        m_mask[0] = 1'b1; m_pend[0] = 1'b0;
      end
      default: iei = v;
    endcase
    wait_cyc(3);
    check_state($sformatf("op%0d_s%0d", op, s));
  endtask

  initial begin
    idle_bus();
    model_reset();
    wait_cyc(3);
    chk("rst_int_n", {7'd0, bus.int_n}, 8'd1);
    chk("rst_vec_oe", {7'd0, bus.vec_oe}, 8'd0);
    chk("rst_vec", bus.vec, 8'h00);
    chk("rst_mask", {5'd0, mask}, 8'h07);
    chk("rst_ieo", {7'd0, ieo}, {7'd0, iei});
    reset = 1'b0;
    wait_cyc(2);

    // Directed opening: masked kb, single kb ack, adc/fire ordering, nesting, simultaneity.
    do_op(0, 0, 0); do_op(1, 0, 0); do_op(0, 0, 0); do_op(3, 0, 0); do_op(4, 0, 0);
    do_op(1, 1, 0); do_op(1, 2, 0); do_op(0, 2, 0); do_op(0, 1, 0);
    do_op(3, 0, 0); do_op(3, 0, 0); do_op(4, 0, 0); do_op(3, 0, 0);
    do_op(0, 0, 0); do_op(3, 0, 0); do_op(4, 0, 0); do_op(4, 0, 0);
    do_op(5, 0, 0); do_op(6, 0, 0); do_op(4, 0, 0);

    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 9);
      int s  = $urandom_range(0, 2);
      bit v  = ($urandom_range(0, 3) == 0);
      if (op == 9) begin op = 7; v = ($urandom_range(0, 3) != 0); end
      else if (op == 8) op = 3;
      else if (op == 7) op = 4;
      do_op(op, s, v);
    end

    // Reset in the middle of an acknowledged INTA.
    iei = 1'b1;
    do_op(1, 0, 0); do_op(0, 0, 0); do_op(1, 2, 0);
    for (int k = 0; k < 3; k++) do_op(4, 0, 0);
    do_op(0, 0, 0);
    @(negedge clk);
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    if (any_elig()) exp_q.push_back(vec_of(elig(0) ? 0 : elig(1) ? 1 : 2));
    wait_cyc(2);
    reset = 1'b1;
    #1;
    chk("midinta_vec_oe", {7'd0, bus.vec_oe}, 8'd0);
    chk("midinta_int_n", {7'd0, bus.int_n}, 8'd1);
    idle_bus();
    model_reset();
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(2);
    check_state("post_rst");
    chk("ack_queue_empty", exp_q.size()[7:0], 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
